// File: rtl/alu_addr_sequencer.sv
// Shared 8-bit ALU owner: arbitrates between single-pass execute ops and two-pass
// 16-bit address generation (6502 indexed / relative addressing with page-cross fix-up).
package control_signals;
   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_AND = 3'd1,
      ALU_OR  = 3'd2,
      ALU_XOR = 3'd3,
      ALU_SR  = 3'd4,
      ALU_SRC = 3'd5
   } alu_op_t;
endpackage

module alu_addr_sequencer #(
   parameter bit EXEC_PRIORITY = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     exec_req,
   input  control_signals::alu_op_t exec_op,
   input  logic [7:0]               exec_a,
   input  logic [7:0]               exec_b,
   input  logic                     exec_carry_in,
   input  logic                     exec_invert_b,
   output logic                     exec_grant,
   input  logic                     addr_req,
   output logic                     addr_ready,
   input  logic [15:0]              addr_base,
   input  logic [7:0]               addr_offset,
   input  logic                     addr_signed,
   input  logic                     addr_force_fix,
   output logic                     addr_done,
   output logic [15:0]              addr_result,
   output logic                     addr_page_crossed,
   output control_signals::alu_op_t alu_operation,
   output logic [7:0]               alu_input_a,
   output logic [7:0]               alu_input_b,
   output logic                     alu_carry_in,
   output logic                     alu_invert_b,
   input  logic [7:0]               alu_result,
   input  logic                     alu_carry,
   output logic [1:0]               dbg_state
);
   import control_signals::*;

   // Handshake: an address request transfers on a rising edge where addr_req && addr_ready;
   // the requester holds addr_req and its operands stable until that edge.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOW  = 2'd1,
      S_HIGH = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] base_q, base_d;
   logic [7:0]  offset_q, offset_d;
   logic        signed_q, signed_d;
   logic        force_q, force_d;
   logic [7:0]  lo_q, lo_d;
   logic        carry_q, carry_d;
   logic        fix_q, fix_d;
   logic [15:0] result_q, result_d;
   logic        crossed_q, crossed_d;

   logic idle;
   logic accept;
   logic fix_low;

   assign idle       = (state_q == S_IDLE);
   assign exec_grant = idle && exec_req && (EXEC_PRIORITY || !addr_req);
   assign addr_ready = idle && !(EXEC_PRIORITY && exec_req);
   assign accept     = addr_req && addr_ready;

   // A negative displacement with no carry out borrows from the high byte; a positive
   // one with carry out increments it. Either way the high byte needs a second pass.
   assign fix_low = signed_q ? (alu_carry ^ offset_q[7]) : alu_carry;

   assign addr_done         = (state_q == S_DONE);
   assign addr_result       = result_q;
   assign addr_page_crossed = crossed_q;
   assign dbg_state         = state_q;

   always_comb begin
      state_d       = state_q;
      base_d        = base_q;
      offset_d      = offset_q;
      signed_d      = signed_q;
      force_d       = force_q;
      lo_d          = lo_q;
      carry_d       = carry_q;
      fix_d         = fix_q;
      result_d      = result_q;
      crossed_d     = crossed_q;
      alu_operation = ALU_ADD;
      alu_input_a   = 8'h00;
      alu_input_b   = 8'h00;
      alu_carry_in  = 1'b0;
      alu_invert_b  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (exec_grant) begin
               alu_operation = exec_op;
               alu_input_a   = exec_a;
               alu_input_b   = exec_b;
               alu_carry_in  = exec_carry_in;
               alu_invert_b  = exec_invert_b;
            end
            if (accept) begin
               base_d   = addr_base;
               offset_d = addr_offset;
               signed_d = addr_signed;
               force_d  = addr_force_fix;
               state_d  = S_LOW;
            end
         end
         S_LOW: begin
            alu_input_a = base_q[7:0];
            alu_input_b = offset_q;
            lo_d        = alu_result;
            carry_d     = alu_carry;
            fix_d       = fix_low;
            if (fix_low || force_q) begin
               state_d = S_HIGH;
            end else begin
               result_d  = {base_q[15:8], alu_result};
               crossed_d = fix_low;
               state_d   = S_DONE;
            end
         end
         S_HIGH: begin
            alu_input_a  = base_q[15:8];
            alu_input_b  = signed_q ? {8{offset_q[7]}} : 8'h00;
            alu_carry_in = carry_q;
            result_d     = {alu_result, lo_q};
            crossed_d    = fix_q;
            state_d      = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         base_q    <= 16'h0000;
         offset_q  <= 8'h00;
         signed_q  <= 1'b0;
         force_q   <= 1'b0;
         lo_q      <= 8'h00;
         carry_q   <= 1'b0;
         fix_q     <= 1'b0;
         result_q  <= 16'h0000;
         crossed_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         offset_q  <= offset_d;
         signed_q  <= signed_d;
         force_q   <= force_d;
         lo_q      <= lo_d;
         carry_q   <= carry_d;
         fix_q     <= fix_d;
         result_q  <= result_d;
         crossed_q <= crossed_d;
      end
   end

endmodule

// File: tb/tb_alu_addr_sequencer.sv
// Scoreboard bench for alu_addr_sequencer: directed address cases, exec contention,
// mid-sequence reset and randomized requests against a plain-arithmetic address model.
module tb_alu_addr_sequencer;
   import control_signals::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        exec_req = 1'b0;
   alu_op_t     exec_op = ALU_ADD;
   logic [7:0]  exec_a = 8'h00;
   logic [7:0]  exec_b = 8'h00;
   logic        exec_carry_in = 1'b0;
   logic        exec_invert_b = 1'b0;
   logic        exec_grant;
   logic        addr_req = 1'b0;
   logic        addr_ready;
   logic [15:0] addr_base = 16'h0000;
   logic [7:0]  addr_offset = 8'h00;
   logic        addr_signed = 1'b0;
   logic        addr_force_fix = 1'b0;
   logic        addr_done;
   logic [15:0] addr_result;
   logic        addr_page_crossed;
   alu_op_t     alu_operation;
   logic [7:0]  alu_input_a;
   logic [7:0]  alu_input_b;
   logic        alu_carry_in;
   logic        alu_invert_b;
   logic [7:0]  alu_result;
   logic        alu_carry;
   logic [1:0]  dbg_state;

   alu_addr_sequencer #(.EXEC_PRIORITY(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .exec_req(exec_req), .exec_op(exec_op), .exec_a(exec_a), .exec_b(exec_b),
      .exec_carry_in(exec_carry_in), .exec_invert_b(exec_invert_b), .exec_grant(exec_grant),
      .addr_req(addr_req), .addr_ready(addr_ready), .addr_base(addr_base),
      .addr_offset(addr_offset), .addr_signed(addr_signed), .addr_force_fix(addr_force_fix),
      .addr_done(addr_done), .addr_result(addr_result), .addr_page_crossed(addr_page_crossed),
      .alu_operation(alu_operation), .alu_input_a(alu_input_a), .alu_input_b(alu_input_b),
      .alu_carry_in(alu_carry_in), .alu_invert_b(alu_invert_b),
      .alu_result(alu_result), .alu_carry(alu_carry), .dbg_state(dbg_state)
   );

   // Clock / reset
   always #5 clk = ~clk;

   int cycle_cnt = 0;
   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   // Combinational adder standing in for the real ALU
   always_comb begin
      logic [8:0] sum;
      sum = {1'b0, alu_input_a} + {1'b0, (alu_invert_b ? ~alu_input_b : alu_input_b)}
            + {8'h00, alu_carry_in};
      alu_result = sum[7:0];
      alu_carry  = sum[8];
   end

   // Scoreboard state
   int          checks = 0;
   int          passed = 0;
   logic [16:0] exp_q[$];   // {page_crossed, result}
   int          lat_q[$];
   int          acc_q[$];
   bit          prev_done = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference: full 16-bit target by plain arithmetic; crossing = high byte changed.
   function automatic logic [18:0] ref_model(input logic [15:0] base, input logic [7:0] off,
                                             input logic sgn, input logic force_fix);
      logic [15:0] disp, tgt;
      logic        crossed;
      logic [1:0]  lat;
      disp    = sgn ? {{8{off[7]}}, off} : {8'h00, off};
      tgt     = base + disp;
      crossed = (tgt[15:8] != base[15:8]);
      lat     = (crossed || force_fix) ? 2'd3 : 2'd2;
      return {lat, crossed, tgt};
   endfunction

   // Driver: call at a negedge; returns at the negedge after the accepting edge.
   task automatic issue(input logic [15:0] base, input logic [7:0] off, input logic sgn,
                        input logic force_fix, input bit noise, input bit track,
                        output int acc_cycle);
      bit          accepted;
      logic [18:0] r;
      accepted       = 1'b0;
      acc_cycle      = -1;
      addr_req       = 1'b1;
      addr_base      = base;
      addr_offset    = off;
      addr_signed    = sgn;
      addr_force_fix = force_fix;
      for (int t = 0; t < 60; t++) begin
         if (t > 0) @(negedge clk);
         exec_req      = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
         exec_op       = alu_op_t'($urandom_range(0, 5));
         exec_a        = 8'($urandom);
         exec_b        = 8'($urandom);
         exec_carry_in = 1'($urandom);
         exec_invert_b = 1'($urandom);
         #1;
         if (addr_ready) begin
            accepted  = 1'b1;
            acc_cycle = cycle_cnt;
            if (track) begin
               r = ref_model(base, off, sgn, force_fix);
               exp_q.push_back(r[16:0]);
               lat_q.push_back(int'(r[18:17]));
               acc_q.push_back(cycle_cnt);
            end
            break;
         end
      end
      if (!accepted) begin
         checks++;
         $display("FAIL accept_timeout: addr_ready never seen for base %0h", base);
      end
      @(negedge clk);
      addr_req = 1'b0;
      exec_req = 1'b0;
   endtask

   // Monitor: pops and compares whenever the DUT presents addr_done
   initial begin
      logic [16:0] e;
      int          l, a;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            prev_done = 1'b0;
            continue;
         end
         if (exec_grant)
            chk("exec_mux", {alu_operation, alu_input_a, alu_input_b, alu_carry_in, alu_invert_b},
                {exec_op, exec_a, exec_b, exec_carry_in, exec_invert_b});
         if (addr_done) begin
            chk("done_pulse_width", prev_done, 1'b0);
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_done: result %0h with nothing outstanding", addr_result);
            end else begin
               e = exp_q.pop_front();
               l = lat_q.pop_front();
               a = acc_q.pop_front();
               chk("addr_result", addr_result, e[15:0]);
               chk("page_crossed", addr_page_crossed, e[16]);
               chk("latency", cycle_cnt - a, l);
            end
         end
         prev_done = addr_done;
      end
   end

   // Main sequence
   initial begin
      int acc, c0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_done", addr_done, 1'b0);
      chk("rst_result", addr_result, 16'h0000);
      chk("rst_crossed", addr_page_crossed, 1'b0);
      chk("rst_state", dbg_state, 2'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("idle_alu_defaults", {alu_operation, alu_input_a, alu_input_b, alu_carry_in, alu_invert_b,
                                exec_grant}, 22'h0);
      @(negedge clk);

      // Directed address cases
      issue(16'h1200, 8'h10, 1'b0, 1'b0, 1'b0, 1'b1, acc);
      issue(16'h12F0, 8'h20, 1'b0, 1'b0, 1'b0, 1'b1, acc);
      issue(16'h1305, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b1, acc);
      issue(16'h1320, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b1, acc);
      issue(16'hFFF0, 8'h20, 1'b0, 1'b0, 1'b0, 1'b1, acc);
      issue(16'h1200, 8'h10, 1'b0, 1'b1, 1'b0, 1'b1, acc);
      issue(16'h0005, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b1, acc);
      issue(16'h1320, 8'hF0, 1'b1, 1'b1, 1'b0, 1'b1, acc);
      repeat (4) @(negedge clk);

      // Exec and addr requests in the same idle cycle: exec wins, addr goes next cycle
      exec_req       = 1'b1;
      exec_op        = ALU_XOR;
      exec_a         = 8'h5A;
      exec_b         = 8'hC3;
      exec_carry_in  = 1'b1;
      exec_invert_b  = 1'b1;
      addr_req       = 1'b1;
      addr_base      = 16'h3456;
      addr_offset    = 8'h22;
      #1;
      c0 = cycle_cnt;
      chk("contend_exec_grant", exec_grant, 1'b1);
      chk("contend_addr_ready", addr_ready, 1'b0);
      chk("contend_alu_a", alu_input_a, 8'h5A);
      chk("contend_alu_op", alu_operation, ALU_XOR);
      @(negedge clk);
      issue(16'h3456, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, acc);
      chk("contend_accept_next", acc - c0, 1);
      repeat (4) @(negedge clk);

      // Reset asserted while the fix-up pass is running
      issue(16'h12F0, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0, acc);
      @(negedge clk);
      #1;
      chk("in_high_state", dbg_state, 2'd2);
      rst_n = 1'b0;
      #1;
      chk("abort_state", dbg_state, 2'd0);
      chk("abort_done", addr_done, 1'b0);
      chk("abort_result", addr_result, 16'h0000);
      chk("abort_crossed", addr_page_crossed, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      issue(16'h12F0, 8'h20, 1'b0, 1'b0, 1'b0, 1'b1, acc);

      // Randomized requests with exec traffic competing for the ALU
      for (int n = 0; n < 40; n++) begin
         issue(16'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
               1'b1, 1'b1, acc);
      end

      for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
      repeat (2) @(negedge clk);
      chk("outstanding_at_end", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
